button_debouncer: RTL and testbench
===================================

# button_debouncer

Debounces the paddle push-buttons using the slow sample clock produced by the frequency divider as a sampling strobe. The block runs entirely in the system clock domain. It synchronises the divided clock and detects its rising edges as single-cycle sample ticks. It then accepts a button change only after the raw input has held for a programmable number of consecutive ticks. Its outputs are clean button levels and single-cycle press/release pulses for the paddle control logic.

## Interface
- NUM_BUTTONS, default 4: number of independent buttons.
- STABLE_TICKS, default 8: consecutive differing samples required to accept a change; legal range 1..255.
- REPEAT_TICKS, default 64: auto-repeat interval in ticks; legal range 1..255; used only when BUTTON_AUTOREPEAT_EN is defined.
- in_clock  input  1  system clock; every register is clocked on its rising edge.
- in_reset_n  input  1  one clock; reset is synchronous and active-low.
- sample_clock  input  1  divided sampling clock from the frequency divider; each phase lasts ≥2 in_clock cycles.
- buttons_raw  input  NUM_BUTTONS  raw button inputs, active-high, asynchronous.
- buttons_level  output  NUM_BUTTONS  debounced level; reset value 0.
- buttons_pressed  output  NUM_BUTTONS  one-cycle pulse on an accepted 0→1 transition (and on auto-repeat); reset value 0.
- buttons_released  output  NUM_BUTTONS  one-cycle pulse on an accepted 1→0 transition; reset value 0.
- sample_tick  output  1  internal tick, exported for debug; reset value 0.

## Operation
- Sample clock path:
  - sample_clock goes through 2-flop synchroniser s1→s2, then a history flop s3.
  - sample_tick = s2 & ~s3 (combinational).
- Each buttons_raw bit goes through its own 2-flop synchroniser; the debounce logic sees only the synchronised value r.
- Each button has an 8-bit counter cnt.
- On an in_clock edge where sample_tick is high, per button:
  - r == buttons_level: cnt←0.
  - r != buttons_level and cnt+1 == STABLE_TICKS: buttons_level←r, cnt←0. In the same edge, buttons_pressed (r=1) or buttons_released (r=0) ←1.
  - Otherwise: cnt←cnt+1.
- On edges without a tick, cnt and buttons_level hold.
- buttons_pressed and buttons_released are registered. They are cleared on every edge unless set by the rules above, so each pulse lasts exactly one cycle.
- Buttons are fully independent. Any combination of pulses in the same cycle is legal.
- A bounce (r returns to level before the count completes) restarts the count from 0.
- STABLE_TICKS=1: a change is accepted on the first tick that sees it.

## Timing
- Tick latency:
  - sample_clock rises before edge k; s2 is high after edge k+1.
  - sample_tick is high for the single cycle between edges k+1 and k+2.
  - The debounce update happens at edge k+2.
- Change latency: a raw change that is stable before edge j reaches r after edge j+1. buttons_level then updates on the STABLE_TICKS-th tick evaluated at or after edge j+2. The pulse is visible in the same cycle as the new level.
- Reset:
  - With in_reset_n low at an edge, all synchroniser flops, counters, levels, pulses and repeat counters ←0.
  - Ticks are ignored while in reset.
  - Reset mid-count discards partial progress; a full STABLE_TICKS run is needed after release.
- sample_clock faster than in_clock/4 is outside specification; missed ticks are permitted.

## Configuration
- BUTTON_AUTOREPEAT_EN defined:
  - Each button gets an 8-bit repeat counter rep. rep←0 on an accepted press and while buttons_level is 0.
  - On each tick with buttons_level=1 and no transition accepted:
    - rep+1 == REPEAT_TICKS: buttons_pressed←1, rep←0.
    - Otherwise: rep←rep+1.
  - Release handling is unchanged.
- BUTTON_AUTOREPEAT_EN undefined: no repeat counters are built, REPEAT_TICKS is ignored, and buttons_pressed fires once per accepted press.

## Test plan
- All cases use STABLE_TICKS=4 and a sample_clock period of 8 in_clock cycles; tick n is the n-th tick after the raw change reaches r.
- Reset: buttons_raw=4'b1111 with in_reset_n low for 3 cycles → all outputs 0. After release, levels stay 0 until tick 4, then buttons_level=4'b1111 and buttons_pressed=4'b1111 for exactly one cycle.
- Clean press: buttons_raw[0] 0→1 held → buttons_level[0] rises at tick 4, buttons_pressed[0] high for one cycle, bits 3:1 unchanged, buttons_released stays 0.
- Bounce: r[1]=1 at ticks 1–2, 0 at tick 3, 1 from tick 4 onward → no pulse until tick 7, when buttons_level[1]=1 and buttons_pressed[1] pulses once.
- Release with simultaneous events: buttons_level=4'b0011 with raw→4'b1100 held → at the 4th tick buttons_level=4'b1100, buttons_pressed=4'b1100 and buttons_released=4'b0011, all in the same cycle.
- Reset mid-count: raw[2] high for 3 ticks, then in_reset_n low for 1 cycle → counter cleared; buttons_level[2] rises only on the 4th tick after reset.
- Auto-repeat (BUTTON_AUTOREPEAT_EN, REPEAT_TICKS=3), raw[0] held high → buttons_pressed[0] pulses at ticks 4, 7 and 10. Without the macro, it pulses at tick 4 only.

Source files
------------

// File: rtl/button_debouncer_if.sv
// Button debouncer signal bundle: raw inputs and sample clock in, clean levels and pulses out.
// No handshake: the pulses are single-cycle strobes with no backpressure, the levels are plain state.
interface button_debouncer_if #(
  parameter int NUM_BUTTONS = 4
);
  logic                   sample_clock;
  logic [NUM_BUTTONS-1:0] buttons_raw;
  logic [NUM_BUTTONS-1:0] buttons_level;
  logic [NUM_BUTTONS-1:0] buttons_pressed;
  logic [NUM_BUTTONS-1:0] buttons_released;
  logic                   sample_tick;

  modport master (
    output sample_clock,
    output buttons_raw,
    input  buttons_level,
    input  buttons_pressed,
    input  buttons_released,
    input  sample_tick
  );

  modport slave (
    input  sample_clock,
    input  buttons_raw,
    output buttons_level,
    output buttons_pressed,
    output buttons_released,
    output sample_tick
  );
endinterface

// File: rtl/button_debouncer.sv
// Tick-sampled push-button debouncer with level and press/release pulse outputs.
// Optional auto-repeat of press pulses is built when BUTTON_AUTOREPEAT_EN is defined.
module button_debouncer #(
  parameter int NUM_BUTTONS  = 4,
  parameter int STABLE_TICKS = 8,
  parameter int REPEAT_TICKS = 64
) (
  input  logic               in_clock,
  input  logic               in_reset_n,
  button_debouncer_if.slave  bus
);

  // Compare against count-1 so an 8-bit counter never has to hold 256.
  localparam logic [7:0] STABLE_LAST = 8'(STABLE_TICKS - 1);

  logic                   samp_s1_q, samp_s2_q, samp_s3_q;
  logic [NUM_BUTTONS-1:0] raw_s1_q, raw_s2_q;
  logic [7:0]             cnt_q [NUM_BUTTONS];
  logic [7:0]             cnt_d [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] level_q, level_d;
  logic [NUM_BUTTONS-1:0] pressed_q, pressed_d;
  logic [NUM_BUTTONS-1:0] released_q, released_d;
  logic [NUM_BUTTONS-1:0] accept;
  logic                   tick;

`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [7:0] REPEAT_LAST = 8'(REPEAT_TICKS - 1);
  logic [7:0] rep_q [NUM_BUTTONS];
  logic [7:0] rep_d [NUM_BUTTONS];
`endif

  assign tick = samp_s2_q & ~samp_s3_q;

  always_comb begin
    cnt_d      = cnt_q;
    level_d    = level_q;
    pressed_d  = '0;
    released_d = '0;
    accept     = '0;
`ifdef BUTTON_AUTOREPEAT_EN
    rep_d      = rep_q;
`endif
    for (int b = 0; b < NUM_BUTTONS; b++) begin
      if (tick) begin
        if (raw_s2_q[b] == level_q[b]) begin
          cnt_d[b] = '0;
        end else if (cnt_q[b] == STABLE_LAST) begin
          accept[b]     = 1'b1;
          level_d[b]    = raw_s2_q[b];
          cnt_d[b]      = '0;
          pressed_d[b]  = raw_s2_q[b];
          released_d[b] = ~raw_s2_q[b];
        end else begin
          cnt_d[b] = cnt_q[b] + 8'd1;
        end
      end
`ifdef BUTTON_AUTOREPEAT_EN
      // An accepted press can only occur while the level is 0, so this also clears on press.
      if (!level_q[b]) begin
        rep_d[b] = '0;
      end else if (tick && !accept[b]) begin
        if (rep_q[b] == REPEAT_LAST) begin
          pressed_d[b] = 1'b1;
          rep_d[b]     = '0;
        end else begin
          rep_d[b] = rep_q[b] + 8'd1;
        end
      end
`endif
    end
  end

  always_ff @(posedge in_clock) begin
    if (!in_reset_n) begin
      samp_s1_q  <= 1'b0;
      samp_s2_q  <= 1'b0;
      samp_s3_q  <= 1'b0;
      raw_s1_q   <= '0;
      raw_s2_q   <= '0;
      level_q    <= '0;
      pressed_q  <= '0;
      released_q <= '0;
      for (int b = 0; b < NUM_BUTTONS; b++) begin
        cnt_q[b] <= '0;
`ifdef BUTTON_AUTOREPEAT_EN
        rep_q[b] <= '0;
`endif
      end
    end else begin
      samp_s1_q  <= bus.sample_clock;
      samp_s2_q  <= samp_s1_q;
      samp_s3_q  <= samp_s2_q;
      raw_s1_q   <= bus.buttons_raw;
      raw_s2_q   <= raw_s1_q;
      level_q    <= level_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      for (int b = 0; b < NUM_BUTTONS; b++) begin
        cnt_q[b] <= cnt_d[b];
`ifdef BUTTON_AUTOREPEAT_EN
        rep_q[b] <= rep_d[b];
`endif
      end
    end
  end

  assign bus.buttons_level    = level_q;
  assign bus.buttons_pressed  = pressed_q;
  assign bus.buttons_released = released_q;
  assign bus.sample_tick      = tick;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: directed table, hand-written corner sequences,
// and randomized stimulus compared every cycle against a tick-index based reference model.
module tb_button_debouncer;

  localparam int NB = 4;
  localparam int ST = 4;
  localparam int RT = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  button_debouncer_if #(.NUM_BUTTONS(NB)) bus ();

  button_debouncer #(
    .NUM_BUTTONS (NB),
    .STABLE_TICKS(ST),
    .REPEAT_TICKS(RT)
  ) dut (
    .in_clock  (clk),
    .in_reset_n(rst_n),
    .bus       (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // ---------------- clock/stimulus generation ----------------
  int samp_half = 4;
  initial begin
    bus.sample_clock = 1'b0;
    forever begin
      repeat (samp_half) @(negedge clk);
      bus.sample_clock = ~bus.sample_clock;
    end
  end

  // ---------------- reference model ----------------
  // A change is accepted once ST ticks have passed since the last tick at which
  // r agreed with the level; repeats fire every RT ticks counted from the press tick.
  logic          m_s1 = 1'b0, m_s2 = 1'b0, m_s3 = 1'b0;
  logic [NB-1:0] m_r1 = '0, m_r2 = '0;
  logic [NB-1:0] e_level = '0, e_press = '0, e_rel = '0;
  logic          e_tick = 1'b0;
  logic          m_tk;
  logic          m_acc;
  int            m_ticks = 0;
  int            last_same [NB];
  int            press_tick [NB];

  initial begin
    for (int b = 0; b < NB; b++) begin
      last_same[b]  = 0;
      press_tick[b] = 0;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_s3 = 1'b0;
      m_r1 = '0;   m_r2 = '0;
      e_level = '0; e_press = '0; e_rel = '0;
      for (int b = 0; b < NB; b++) last_same[b] = m_ticks;
    end else begin
      m_tk    = m_s2 & ~m_s3;
      e_press = '0;
      e_rel   = '0;
      if (m_tk) begin
        m_ticks++;
        for (int b = 0; b < NB; b++) begin
          m_acc = 1'b0;
          if (m_r2[b] == e_level[b]) begin
            last_same[b] = m_ticks;
          end else if (m_ticks - last_same[b] >= ST) begin
            m_acc        = 1'b1;
            e_level[b]   = m_r2[b];
            e_press[b]   = m_r2[b];
            e_rel[b]     = ~m_r2[b];
            last_same[b] = m_ticks;
            if (m_r2[b]) press_tick[b] = m_ticks;
          end
`ifdef BUTTON_AUTOREPEAT_EN
          if (!m_acc && e_level[b] && ((m_ticks - press_tick[b]) % RT == 0)) e_press[b] = 1'b1;
`endif
        end
      end
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = bus.sample_clock;
      m_r2 = m_r1; m_r1 = bus.buttons_raw;
    end
    e_tick = m_s2 & ~m_s3;
  end

  // ---------------- scoreboard / monitor ----------------
  logic [NB-1:0] seen_p = '0, seen_r = '0;
  int            np = 0;

  always @(negedge clk) begin
    chk("cyc_level", bus.buttons_level, e_level);
    chk("cyc_pressed", bus.buttons_pressed, e_press);
    chk("cyc_released", bus.buttons_released, e_rel);
    chk("cyc_tick", NB'(bus.sample_tick), NB'(e_tick));
    seen_p = seen_p | bus.buttons_pressed;
    seen_r = seen_r | bus.buttons_released;
    if (bus.buttons_pressed != '0) np++;
  end

  task automatic clear_seen();
    seen_p = '0;
    seen_r = '0;
    np     = 0;
  endtask

  task automatic cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    int target;
    int budget;
    target = m_ticks + n;
    budget = n * 40 + 40;
    while (m_ticks < target && budget > 0) begin
      cycle();
      budget--;
    end
    tests++;
    if (m_ticks < target) begin
      fails++;
      $display("FAIL wait_ticks: reached %0d ticks, required %0d", m_ticks, target);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [NB-1:0] raw;
    int            ticks;
    logic [NB-1:0] lvl;
    logic [NB-1:0] prs;
    logic [NB-1:0] rel;
  } vec_t;

  vec_t vecs [7];
  logic exp_rep;

  initial begin
    vecs[0] = '{raw: 4'b0000, ticks: 5, lvl: 4'b0000, prs: 4'b0000, rel: 4'b1111};
    vecs[1] = '{raw: 4'b0001, ticks: 5, lvl: 4'b0001, prs: 4'b0001, rel: 4'b0000};
    vecs[2] = '{raw: 4'b0011, ticks: 5, lvl: 4'b0011, prs: 4'b0010, rel: 4'b0000};
    vecs[3] = '{raw: 4'b1100, ticks: 5, lvl: 4'b1100, prs: 4'b1100, rel: 4'b0011};
    vecs[4] = '{raw: 4'b1100, ticks: 3, lvl: 4'b1100, prs: 4'b0000, rel: 4'b0000};
    vecs[5] = '{raw: 4'b0110, ticks: 5, lvl: 4'b0110, prs: 4'b0010, rel: 4'b1000};
    vecs[6] = '{raw: 4'b0000, ticks: 5, lvl: 4'b0000, prs: 4'b0000, rel: 4'b0110};

    // Reset with all buttons held.
    bus.buttons_raw = 4'b1111;
    rst_n = 1'b0;
    repeat (3) cycle();
    chk("rst_level", bus.buttons_level, 4'b0000);
    chk("rst_pressed", bus.buttons_pressed, 4'b0000);
    chk("rst_released", bus.buttons_released, 4'b0000);
    chk("rst_tick", NB'(bus.sample_tick), 4'b0000);
    rst_n = 1'b1;
    clear_seen();
    wait_ticks(3);
    chk("rst_hold_level", bus.buttons_level, 4'b0000);
    wait_ticks(1);
    chk("rst_accept_level", bus.buttons_level, 4'b1111);
    chk("rst_accept_pressed", bus.buttons_pressed, 4'b1111);
    cycle();
    chk("rst_pulse_end", bus.buttons_pressed, 4'b0000);
    chk("rst_pulse_count", NB'(np), 4'd1);

    for (int i = 0; i < 7; i++) begin
      bus.buttons_raw = vecs[i].raw;
      clear_seen();
      wait_ticks(vecs[i].ticks);
      chk($sformatf("vec%0d_level", i), bus.buttons_level, vecs[i].lvl);
`ifndef BUTTON_AUTOREPEAT_EN
      chk($sformatf("vec%0d_pressed", i), seen_p, vecs[i].prs);
`endif
      chk($sformatf("vec%0d_released", i), seen_r, vecs[i].rel);
    end

    // Bounce on button 1: 1,1,0 then steady 1 -> accepted on tick 7.
    wait_ticks(1);
    bus.buttons_raw = 4'b0010;
    wait_ticks(2);
    chk("bounce_early_level", bus.buttons_level, 4'b0000);
    bus.buttons_raw = 4'b0000;
    wait_ticks(1);
    bus.buttons_raw = 4'b0010;
    clear_seen();
    wait_ticks(3);
    chk("bounce_hold_level", bus.buttons_level, 4'b0000);
    chk("bounce_no_pulse", seen_p, 4'b0000);
    wait_ticks(1);
    chk("bounce_level", bus.buttons_level, 4'b0010);
    chk("bounce_pressed", bus.buttons_pressed, 4'b0010);

    // Reset in the middle of a count on button 2.
    bus.buttons_raw = 4'b0000;
    wait_ticks(5);
    chk("mid_pre_level", bus.buttons_level, 4'b0000);
    wait_ticks(1);
    bus.buttons_raw = 4'b0100;
    wait_ticks(3);
    rst_n = 1'b0;
    cycle();
    chk("mid_rst_level", bus.buttons_level, 4'b0000);
    rst_n = 1'b1;
    wait_ticks(3);
    chk("mid_hold_level", bus.buttons_level, 4'b0000);
    wait_ticks(1);
    chk("mid_level", bus.buttons_level, 4'b0100);
    chk("mid_pressed", bus.buttons_pressed, 4'b0100);

    // Held press on button 0: repeat pulses only when auto-repeat is built.
    bus.buttons_raw = 4'b0000;
    wait_ticks(5);
    wait_ticks(1);
    bus.buttons_raw = 4'b0001;
    for (int n = 1; n <= 11; n++) begin
      wait_ticks(1);
`ifdef BUTTON_AUTOREPEAT_EN
      exp_rep = (n == 4) || (n == 7) || (n == 10);
`else
      exp_rep = (n == 4);
`endif
      chk($sformatf("hold_tick%0d_pressed0", n), NB'(bus.buttons_pressed[0]), NB'(exp_rep));
    end

    // Randomized: chattering inputs, varying sample rate, occasional resets.
    for (int i = 0; i < 300; i++) begin
      samp_half       = $urandom_range(2, 5);
      bus.buttons_raw = NB'($urandom_range(0, 15));
      if ($urandom_range(0, 24) == 0) begin
        rst_n = 1'b0;
        repeat ($urandom_range(1, 2)) cycle();
        rst_n = 1'b1;
      end
      repeat ($urandom_range(1, 40)) cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
